// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types and rounding helper for the square-root result path
package sqrt_pkg;

  localparam int SQRT_DATAWIDTH = 32;

  // One buffered result. exact sits in the LSB so a cleared entry reads as all zeros.
  typedef struct packed {
    logic [SQRT_DATAWIDTH-1:0] root_rnd;
    logic [SQRT_DATAWIDTH-1:0] root;
    logic                      exact;
  } sqrt_result_t;

  // Round to nearest. With radicand = root^2 + rem, the radicand is closer to
  // (root+1)^2 exactly when rem > root. A tie cannot occur for integer radicands.
  function automatic logic [SQRT_DATAWIDTH-1:0] round_root(
    input logic [SQRT_DATAWIDTH-1:0] root,
    input logic [SQRT_DATAWIDTH-1:0] rem
  );
    return root + SQRT_DATAWIDTH'(rem > root);
  endfunction

endpackage

// File: rtl/sqrt_fifo.sv
// rtl/sqrt_fifo.sv - show-ahead synchronous FIFO of sqrt_result_t entries
module sqrt_fifo
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  sqrt_result_t               i_data,
  output sqrt_result_t               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [$clog2(DEPTH):0]     o_count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sqrt_result_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push_ok;
  logic           pop_ok;

  // A pop needs a stored entry; a push into a full FIFO only lands if a pop frees a slot
  // in the same cycle. An empty FIFO never pops, so push+pop on empty is push-only.
  assign o_empty      = (count == '0);
  assign o_full       = (count == CW'(DEPTH));
  assign pop_ok       = i_pop && !o_empty;
  assign push_ok      = i_push && (!o_full || pop_ok);
  assign o_count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign o_count      = count;

  // Head entry is presented combinationally; zeros while empty so stale data never leaks.
  assign o_data = o_empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy state; pointers wrap naturally, count alone tracks fullness.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= o_count_next;
    end
  end

  // Storage array write; no reset needed because count gates visibility.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/sqrt_result_buffer.sv
// rtl/sqrt_result_buffer.sv - rounds square_root results and buffers them with throttle and overflow flags
module sqrt_result_buffer
  import sqrt_pkg::*;
#(
  parameter int DATAWIDTH    = SQRT_DATAWIDTH,
  parameter int DEPTH        = 32,
  parameter int PIPE_LATENCY = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [DATAWIDTH-1:0]     i_root,
  input  logic [DATAWIDTH-1:0]     i_remainder,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATAWIDTH-1:0]     o_root,
  output logic [DATAWIDTH-1:0]     o_root_rnd,
  output logic                     o_exact,
  output logic                     o_almost_full,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int CW       = $clog2(DEPTH) + 1;
  // Stopping issue at this level still leaves room for every result already in flight.
  localparam int AF_LEVEL = DEPTH - PIPE_LATENCY - 1;

  sqrt_result_t   wr_data;
  sqrt_result_t   head;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count_next;
  logic           drop;

  // The struct is sized by the package, so DATAWIDTH must stay at SQRT_DATAWIDTH.
  assign wr_data.root     = i_root;
  assign wr_data.root_rnd = round_root(i_root, i_remainder);
  assign wr_data.exact    = (i_remainder == '0);

  sqrt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (i_valid),
    .i_pop        (i_ready),
    .i_data       (wr_data),
    .o_data       (head),
    .o_full       (full),
    .o_empty      (empty),
    .o_count      (o_count),
    .o_count_next (count_next)
  );

  assign o_valid    = !empty;
  assign o_root     = head.root;
  assign o_root_rnd = head.root_rnd;
  assign o_exact    = head.exact;

  // A result is lost only when full and nothing leaves this cycle (full implies non-empty).
  assign drop = i_valid && full && !i_ready;

  // Sticky overflow and registered almost-full throttle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow    <= 1'b0;
      o_almost_full <= 1'b0;
    end else begin
      if (drop) o_overflow <= 1'b1;
      o_almost_full <= (count_next >= CW'(AF_LEVEL));
    end
  end

endmodule

// File: tb/tb_sqrt_result_buffer.sv
// tb/tb_sqrt_result_buffer.sv - self-checking bench for sqrt_result_buffer
module tb_sqrt_result_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int PL    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic [DW-1:0] i_root;
  logic [DW-1:0] i_remainder;
  logic          i_ready;
  logic          o_valid;
  logic [DW-1:0] o_root;
  logic [DW-1:0] o_root_rnd;
  logic          o_exact;
  logic          o_almost_full;
  logic          o_overflow;
  logic [CW-1:0] o_count;

  always #5 i_clk = ~i_clk;

  sqrt_result_buffer #(
    .DATAWIDTH    (DW),
    .DEPTH        (DEPTH),
    .PIPE_LATENCY (PL)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .i_root        (i_root),
    .i_remainder   (i_remainder),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_root        (o_root),
    .o_root_rnd    (o_root_rnd),
    .o_exact       (o_exact),
    .o_almost_full (o_almost_full),
    .o_overflow    (o_overflow),
    .o_count       (o_count)
  );

  typedef struct {
    logic [DW-1:0] root;
    logic [DW-1:0] rnd;
    logic          exact;
  } ent_t;

  typedef struct {
    logic          valid;
    logic [DW-1:0] root;
    logic [DW-1:0] rem;
    logic          ready;
    logic          rst;
    logic          exp_valid;
    logic [DW-1:0] exp_root;
    logic [DW-1:0] exp_rnd;
    logic          exp_exact;
    int            exp_count;
  } vec_t;

  ent_t q[$];
  bit   m_ovf;
  bit   m_af;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Nearest integer root from distances of the radicand to the two bracketing squares.
  function automatic ent_t ref_entry(input logic [DW-1:0] root, input logic [DW-1:0] rem);
    ent_t e;
    longint unsigned r, rad, d_lo, d_hi;
    r    = longint'(root);
    rad  = r * r + longint'(rem);
    d_lo = rad - r * r;
    d_hi = (r + 1) * (r + 1) - rad;
    e.root  = root;
    e.rnd   = (d_hi < d_lo) ? DW'(r + 1) : root;
    e.exact = (rad == r * r);
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    ent_t h;
    h = '{root: '0, rnd: '0, exact: 1'b0};
    if (q.size() > 0) h = q[0];
    chk({tag, ".valid"}, 64'(o_valid), 64'(q.size() > 0));
    chk({tag, ".count"}, 64'(o_count), 64'(q.size()));
    chk({tag, ".af"}, 64'(o_almost_full), 64'(m_af));
    chk({tag, ".ovf"}, 64'(o_overflow), 64'(m_ovf));
    chk({tag, ".root"}, 64'(o_root), 64'(h.root));
    chk({tag, ".rnd"}, 64'(o_root_rnd), 64'(h.rnd));
    chk({tag, ".exact"}, 64'(o_exact), 64'(h.exact));
  endtask

  task automatic step(input logic v, input logic [DW-1:0] root, input logic [DW-1:0] rem,
                      input logic rdy, input logic rst, input string tag);
    bit pop;
    i_valid     = v;
    i_root      = root;
    i_remainder = rem;
    i_ready     = rdy;
    i_rst       = rst;
    @(posedge i_clk);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_af  = 1'b0;
    end else begin
      pop = rdy && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (v) begin
        if (q.size() < DEPTH) q.push_back(ref_entry(root, rem));
        else m_ovf = 1'b1;
      end
      m_af = (q.size() >= DEPTH - PL - 1);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic rand_pair(output logic [DW-1:0] root, output logic [DW-1:0] rem);
    int unsigned r;
    r    = $urandom_range(0, 16'hFFFF);
    root = DW'(r);
    rem  = DW'($urandom_range(0, 2 * r));
  endtask

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] r, m;

    vecs[0] = '{1'b1, 32'd5,      32'd6,       1'b0, 1'b0, 1'b1, 32'd5,      32'd6,       1'b0, 1};
    vecs[1] = '{1'b1, 32'd5,      32'd5,       1'b1, 1'b0, 1'b1, 32'd5,      32'd5,       1'b0, 1};
    vecs[2] = '{1'b1, 32'd4,      32'd0,       1'b1, 1'b0, 1'b1, 32'd4,      32'd4,       1'b1, 1};
    vecs[3] = '{1'b1, 32'hFFFF,   32'h1FFFE,   1'b1, 1'b0, 1'b1, 32'hFFFF,   32'h10000,   1'b0, 1};
    vecs[4] = '{1'b0, 32'd0,      32'd0,       1'b1, 1'b0, 1'b0, 32'd0,      32'd0,       1'b0, 0};
    vecs[5] = '{1'b0, 32'd9,      32'd9,       1'b1, 1'b0, 1'b0, 32'd0,      32'd0,       1'b0, 0};
    vecs[6] = '{1'b1, 32'd7,      32'd3,       1'b1, 1'b0, 1'b1, 32'd7,      32'd7,       1'b0, 1};
    vecs[7] = '{1'b1, 32'd3,      32'd0,       1'b0, 1'b1, 1'b0, 32'd0,      32'd0,       1'b0, 0};

    q.delete();
    m_ovf = 1'b0;
    m_af  = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b1, "rst0");
    step(1'b0, '0, '0, 1'b0, 1'b1, "rst1");
    chk("reset.count", 64'(o_count), 64'd0);
    chk("reset.valid", 64'(o_valid), 64'd0);

    // Directed table: rounding, ordering, max radicand, empty push+pop, reset with push.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].valid, vecs[i].root, vecs[i].rem, vecs[i].ready, vecs[i].rst, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.valid", i), 64'(o_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("tbl%0d.root", i), 64'(o_root), 64'(vecs[i].exp_root));
      chk($sformatf("tbl%0d.rnd", i), 64'(o_root_rnd), 64'(vecs[i].exp_rnd));
      chk($sformatf("tbl%0d.exact", i), 64'(o_exact), 64'(vecs[i].exp_exact));
      chk($sformatf("tbl%0d.count", i), 64'(o_count), 64'(vecs[i].exp_count));
    end

    // Fill to full with no consumer, then overflow, then drain in order.
    step(1'b0, '0, '0, 1'b0, 1'b1, "rstB");
    for (int k = 1; k <= DEPTH; k++) begin
      rand_pair(r, m);
      step(1'b1, r, m, 1'b0, 1'b0, "fill");
      chk($sformatf("fill%0d.af", k), 64'(o_almost_full), 64'(k >= DEPTH - PL - 1));
    end
    chk("full.count", 64'(o_count), 64'(DEPTH));
    chk("full.ovf", 64'(o_overflow), 64'd0);
    step(1'b1, 32'd123, 32'd1, 1'b0, 1'b0, "push33");
    chk("push33.ovf", 64'(o_overflow), 64'd1);
    chk("push33.count", 64'(o_count), 64'(DEPTH));
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b1, 1'b0, "drainB");
    chk("drainB.count", 64'(o_count), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, "drainB.idle");
    chk("drainB.ovf_sticky", 64'(o_overflow), 64'd1);

    // Full FIFO streaming push+pop across pointer wrap.
    step(1'b0, '0, '0, 1'b0, 1'b1, "rstC");
    for (int k = 0; k < DEPTH; k++) begin
      rand_pair(r, m);
      step(1'b1, r, m, 1'b0, 1'b0, "fillC");
    end
    for (int k = 0; k < 40; k++) begin
      rand_pair(r, m);
      step(1'b1, r, m, 1'b1, 1'b0, "stream");
      chk("stream.count", 64'(o_count), 64'(DEPTH));
      chk("stream.ovf", 64'(o_overflow), 64'd0);
    end
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, 1'b1, 1'b0, "drainC");

    // Reset with ten entries stored and a push in the reset cycle.
    for (int k = 0; k < 10; k++) begin
      rand_pair(r, m);
      step(1'b1, r, m, 1'b0, 1'b0, "fillD");
    end
    step(1'b1, 32'd77, 32'd2, 1'b0, 1'b1, "rstD");
    chk("rstD.count", 64'(o_count), 64'd0);
    chk("rstD.valid", 64'(o_valid), 64'd0);
    chk("rstD.ovf", 64'(o_overflow), 64'd0);
    chk("rstD.af", 64'(o_almost_full), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, "rstD.after");
    chk("rstD.absent", 64'(o_valid), 64'd0);

    // Randomised traffic with phases biased toward filling and draining.
    for (int k = 0; k < 3000; k++) begin
      int vp, rp;
      vp = ((k / 200) % 2 == 0) ? 80 : 40;
      rp = ((k / 200) % 2 == 0) ? 40 : 80;
      rand_pair(r, m);
      step(($urandom_range(0, 99) < vp), r, m, ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 999) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_result_buffer.md
Name: sqrt_result_buffer

Overview:
- Sits directly downstream of the square_root pipeline and consumes its root/remainder pair on every valid cycle.
- Derives the round-to-nearest root and an exact-square flag, then buffers results in a synchronous FIFO with a ready/valid output.
- The pipeline cannot stall, so the block publishes an almost-full throttle for the issuing logic and a sticky overflow flag for lost results.

Parameters:
- DATAWIDTH, 32, radicand/root/remainder width; matches the square_root instance.
- DEPTH, 32, FIFO entries; power of two; must exceed PIPE_LATENCY+1.
- PIPE_LATENCY, 16, square_root cycles from i_valid to o_valid (DATAWIDTH/2); sets the almost-full threshold.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  result strobe from square_root o_valid
- i_root  in  DATAWIDTH  truncated root from square_root
- i_remainder  in  DATAWIDTH  remainder from square_root
- o_valid  out  1  head entry available
- i_ready  in  1  consumer accepts the head entry
- o_root  out  DATAWIDTH  truncated root, head entry
- o_root_rnd  out  DATAWIDTH  rounded root, head entry
- o_exact  out  1  head radicand is a perfect square
- o_almost_full  out  1  upstream must stop issuing into square_root
- o_overflow  out  1  sticky: a result was dropped
- o_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (synchronous, i_rst=1 at a posedge): pointers=0, count=0, o_valid=0, o_almost_full=0, o_overflow=0. Data outputs read 0 while empty. Reset mid-operation flushes all entries; i_valid in the reset cycle is ignored.
- Rounding (combinational, before write): o_root_rnd = i_root + (i_remainder > i_root). exact = (i_remainder == 0). Arithmetic is DATAWIDTH wide. No overflow is possible because a valid root occupies at most DATAWIDTH/2 bits.
- Push: i_valid=1 writes {root, root_rnd, exact} at the posedge ending that cycle.
- Latency: if the FIFO was empty, o_valid rises in the next cycle (1-cycle latency).
- Output is show-ahead: o_root/o_root_rnd/o_exact reflect the head entry whenever o_valid=1.
- Pop: occurs at a posedge when o_valid && i_ready. i_ready is ignored while o_valid=0.
- Simultaneous push+pop when not empty: count is unchanged and both pointers advance.
- Full (count==DEPTH):
  - push+pop in the same cycle: push accepted, count stays DEPTH.
  - push without pop: entry dropped, FIFO contents untouched, o_overflow set.
- o_overflow: once set, it clears only on i_rst.
- Push and pop on the same cycle into an empty FIFO: only the push takes effect (o_valid was 0).
- Wrap-around: read/write pointers are $clog2(DEPTH) bits and wrap naturally. count tracks fullness, so there is no pointer-MSB trick.
- o_almost_full is registered and equals (count_next >= DEPTH-PIPE_LATENCY-1). This guarantees no overflow if issue stops the cycle it asserts, since up to PIPE_LATENCY results can still be in flight.
- o_count is registered and equals the number of stored entries.

Decomposition:
- sqrt_pkg holds:
  - the DATAWIDTH default constant;
  - the typedef sqrt_result_t, a packed struct {root_rnd, root, exact};
  - the function round_root(root, rem).
- One sub-module, sqrt_fifo: a generic synchronous FIFO of sqrt_result_t providing push/pop/full/empty/count.
- The top level adds rounding, the overflow sticky and almost-full.

Test Plan:
- Single push of root=5, rem=6 (radicand 31) -> next cycle o_valid=1, o_root=5, o_root_rnd=6, o_exact=0.
- Pushes of (5,5) radicand 30, then (4,0) radicand 16, with i_ready=1 -> o_root_rnd=5 exact=0, then o_root_rnd=4 exact=1, in order.
- Max radicand 0xFFFFFFFF: root=0xFFFF, rem=0x1FFFE -> o_root_rnd=0x10000, o_exact=0.
- i_ready=0, 32 pushes -> o_count=32. o_almost_full asserts when the next count reaches 15. A 33rd push sets o_overflow, and draining yields exactly the first 32 entries in order.
- Full FIFO, push+pop in the same cycle for 40 cycles -> count stays 32, o_overflow stays 0, and pointers wrap with data order preserved.
- 10 entries stored, i_rst=1 for one cycle with i_valid=1 -> next cycle o_count=0, o_valid=0, o_overflow=0, o_almost_full=0, and the reset-cycle entry is absent.
